// File: rtl/axi_write_responder_if.sv
// rtl/axi_write_responder_if.sv - AXI4 write channel group plus memory write port bundle
interface axi_write_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) ();
    logic                      aw_valid_i;
    logic                      aw_ready_o;
    logic [ADDR_WIDTH-1:0]     aw_addr_i;
    logic [7:0]                aw_len_i;
    logic [ID_WIDTH-1:0]       aw_id_i;
    logic                      w_valid_i;
    logic                      w_ready_o;
    logic [DATA_WIDTH-1:0]     w_data_i;
    logic [DATA_WIDTH/8-1:0]   w_strb_i;
    logic                      w_last_i;
    logic                      b_valid_o;
    logic                      b_ready_i;
    logic [ID_WIDTH-1:0]       b_id_o;
    logic [1:0]                b_resp_o;
    logic                      mem_req_o;
    logic                      mem_gnt_i;
    logic [ADDR_WIDTH-1:0]     mem_addr_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic [DATA_WIDTH/8-1:0]   mem_be_o;

    modport slave (
        input  aw_valid_i, aw_addr_i, aw_len_i, aw_id_i,
        input  w_valid_i, w_data_i, w_strb_i, w_last_i,
        input  b_ready_i, mem_gnt_i,
        output aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output aw_valid_i, aw_addr_i, aw_len_i, aw_id_i,
        output w_valid_i, w_data_i, w_strb_i, w_last_i,
        output b_ready_i, mem_gnt_i,
        input  aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o,
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/axi_write_responder.sv
// rtl/axi_write_responder.sv - AXI4 write subordinate terminating INCR bursts on a req/gnt memory port
module axi_write_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi_write_responder_if.slave bus
);
    localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DRAIN,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  err_q, err_d;
    logic                  last_exp;
    logic                  beat;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign last_exp        = (cnt_q == len_q);
    assign beat            = bus.w_valid_i & bus.mem_gnt_i;
    // Beat address wraps silently at the top of the address space.
    assign bus.mem_addr_o  = addr_q + (ADDR_WIDTH'(cnt_q) << BEAT_SHIFT);
    assign bus.mem_wdata_o = bus.w_data_i;
    assign bus.mem_be_o    = bus.w_strb_i;
    assign bus.b_id_o      = id_q;
    assign bus.b_resp_o    = err_q ? 2'b10 : 2'b00;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        id_d           = id_q;
        err_d          = err_q;
        bus.aw_ready_o = 1'b0;
        bus.w_ready_o  = 1'b0;
        bus.b_valid_o  = 1'b0;
        bus.mem_req_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.aw_ready_o = 1'b1;
                if (bus.aw_valid_i) begin
                    addr_d  = bus.aw_addr_i;
                    len_d   = bus.aw_len_i;
                    id_d    = bus.aw_id_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                bus.mem_req_o = bus.w_valid_i;
                bus.w_ready_o = beat;
                if (beat) begin
                    if (bus.w_last_i) begin
                        err_d   = err_q | ~last_exp;
                        state_d = RESP;
                    end else if (last_exp) begin
                        // Master overran the burst length: swallow beats until its last.
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                bus.w_ready_o = 1'b1;
                if (bus.w_valid_i && bus.w_last_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.b_valid_o = 1'b1;
                if (bus.b_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_write_responder.sv
// tb/tb_axi_write_responder.sv - scoreboard bench for axi_write_responder
module tb_axi_write_responder;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_write_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_write_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
    } mem_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_t;

    mem_t mem_q[$];
    b_t   b_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic gnt_phase;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endfunction

    task automatic exp_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_t e;
        e.addr = a;
        e.data = d;
        e.be   = 8'hFF;
        mem_q.push_back(e);
    endtask

    task automatic exp_b(input logic [IW-1:0] id, input logic [1:0] resp);
        b_t e;
        e.id   = id;
        e.resp = resp;
        b_q.push_back(e);
    endtask

    // Monitor: every memory write and every B handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req_o && bus.mem_gnt_i) begin
                if (mem_q.size() == 0) begin
                    fail($sformatf("unexpected mem write addr %h", bus.mem_addr_o));
                end else begin
                    mem_t e;
                    e = mem_q.pop_front();
                    check("mem_addr", 64'(bus.mem_addr_o), 64'(e.addr));
                    check("mem_wdata", bus.mem_wdata_o, e.data);
                    check("mem_be", 64'(bus.mem_be_o), 64'(e.be));
                end
            end
            if (bus.b_valid_o && bus.b_ready_i) begin
                if (b_q.size() == 0) begin
                    fail($sformatf("unexpected B id %h resp %h", bus.b_id_o, bus.b_resp_o));
                end else begin
                    b_t e;
                    e = b_q.pop_front();
                    check("b_id", 64'(bus.b_id_o), 64'(e.id));
                    check("b_resp", 64'(bus.b_resp_o), 64'(e.resp));
                end
            end
        end
    end

    task automatic send_aw(input logic [AW-1:0] a, input logic [7:0] len, input logic [IW-1:0] id);
        logic ok;
        ok = 1'b0;
        bus.aw_valid_i = 1'b1;
        bus.aw_addr_i  = a;
        bus.aw_len_i   = len;
        bus.aw_id_i    = id;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = bus.aw_ready_o;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.aw_valid_i = 1'b0;
        if (!ok) fail("aw handshake timeout");
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic last, input logic toggle, input logic drain);
        logic ok;
        ok = 1'b0;
        bus.w_valid_i = 1'b1;
        bus.w_data_i  = d;
        bus.w_strb_i  = 8'hFF;
        bus.w_last_i  = last;
        for (int i = 0; i < 50; i++) begin
            if (toggle) begin
                bus.mem_gnt_i = gnt_phase;
                gnt_phase     = ~gnt_phase;
            end
            @(negedge clk);
            if (!bus.mem_gnt_i) check("w_ready_on_gnt0", 64'(bus.w_ready_o), 64'(0));
            ok = bus.w_ready_o;
            if (ok && drain) check("drain_mem_req", 64'(bus.mem_req_o), 64'(0));
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.w_valid_i = 1'b0;
        bus.w_last_i  = 1'b0;
        if (!ok) fail("w handshake timeout");
    endtask

    task automatic take_b(input logic [IW-1:0] id, input logic [1:0] resp, input int stall);
        logic ok;
        ok = 1'b0;
        bus.b_ready_i = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("b_valid_held", 64'(bus.b_valid_o), 64'(1));
            check("b_id_held", 64'(bus.b_id_o), 64'(id));
            check("b_resp_held", 64'(bus.b_resp_o), 64'(resp));
            check("aw_ready_in_resp", 64'(bus.aw_ready_o), 64'(0));
        end
        @(posedge clk);
        #1;
        bus.b_ready_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = bus.b_valid_o;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.b_ready_i = 1'b0;
        if (!ok) fail("b handshake timeout");
    endtask

    task automatic queues_empty(input string name);
        check({name, "_mem_left"}, 64'(mem_q.size()), 64'(0));
        check({name, "_b_left"}, 64'(b_q.size()), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.aw_valid_i = 1'b0;
        bus.aw_addr_i  = '0;
        bus.aw_len_i   = '0;
        bus.aw_id_i    = '0;
        bus.w_valid_i  = 1'b0;
        bus.w_data_i   = '0;
        bus.w_strb_i   = '0;
        bus.w_last_i   = 1'b0;
        bus.b_ready_i  = 1'b0;
        bus.mem_gnt_i  = 1'b1;
        gnt_phase      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, and W must not be accepted in IDLE.
        @(negedge clk);
        check("rst_aw_ready", 64'(bus.aw_ready_o), 64'(1));
        check("rst_w_ready", 64'(bus.w_ready_o), 64'(0));
        check("rst_b_valid", 64'(bus.b_valid_o), 64'(0));
        check("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
        check("rst_b_resp", 64'(bus.b_resp_o), 64'(0));
        check("rst_b_id", 64'(bus.b_id_o), 64'(0));
        @(posedge clk);
        #1;
        bus.w_valid_i = 1'b1;
        @(negedge clk);
        check("idle_w_ready", 64'(bus.w_ready_o), 64'(0));
        check("idle_mem_req", 64'(bus.mem_req_o), 64'(0));
        @(posedge clk);
        #1;
        bus.w_valid_i = 1'b0;

        // Single beat.
        exp_mem(32'h0000_0100, 64'h1111_2222_3333_4444);
        exp_b(4'd3, 2'b00);
        send_aw(32'h0000_0100, 8'd0, 4'd3);
        send_w(64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0);
        take_b(4'd3, 2'b00, 1);
        queues_empty("single");

        // Burst with toggling grant.
        exp_mem(32'h0000_1000, 64'hA0);
        exp_mem(32'h0000_1008, 64'hA1);
        exp_mem(32'h0000_1010, 64'hA2);
        exp_mem(32'h0000_1018, 64'hA3);
        exp_b(4'd4, 2'b00);
        send_aw(32'h0000_1000, 8'd3, 4'd4);
        gnt_phase = 1'b1;
        send_w(64'hA0, 1'b0, 1'b1, 1'b0);
        send_w(64'hA1, 1'b0, 1'b1, 1'b0);
        send_w(64'hA2, 1'b0, 1'b1, 1'b0);
        send_w(64'hA3, 1'b1, 1'b1, 1'b0);
        bus.mem_gnt_i = 1'b1;
        take_b(4'd4, 2'b00, 0);
        queues_empty("toggle");

        // Early last, then a normal burst.
        exp_mem(32'h0000_4000, 64'hB0);
        exp_mem(32'h0000_4008, 64'hB1);
        exp_b(4'd7, 2'b10);
        send_aw(32'h0000_4000, 8'd3, 4'd7);
        send_w(64'hB0, 1'b0, 1'b0, 1'b0);
        send_w(64'hB1, 1'b1, 1'b0, 1'b0);
        take_b(4'd7, 2'b10, 1);
        exp_mem(32'h0000_4100, 64'hB8);
        exp_b(4'd8, 2'b00);
        send_aw(32'h0000_4100, 8'd0, 4'd8);
        send_w(64'hB8, 1'b1, 1'b0, 1'b0);
        take_b(4'd8, 2'b00, 0);
        queues_empty("early");

        // Missing last: beats 3-4 drained.
        exp_mem(32'h0000_3000, 64'hC0);
        exp_mem(32'h0000_3008, 64'hC1);
        exp_b(4'd2, 2'b10);
        send_aw(32'h0000_3000, 8'd1, 4'd2);
        send_w(64'hC0, 1'b0, 1'b0, 1'b0);
        send_w(64'hC1, 1'b0, 1'b0, 1'b0);
        send_w(64'hC2, 1'b0, 1'b0, 1'b1);
        send_w(64'hC3, 1'b1, 1'b0, 1'b1);
        take_b(4'd2, 2'b10, 1);
        queues_empty("missing");

        // Address wrap plus B stall.
        exp_mem(32'hFFFF_FFF8, 64'hD0);
        exp_mem(32'h0000_0000, 64'hD1);
        exp_b(4'd9, 2'b00);
        send_aw(32'hFFFF_FFF8, 8'd1, 4'd9);
        send_w(64'hD0, 1'b0, 1'b0, 1'b0);
        send_w(64'hD1, 1'b1, 1'b0, 1'b0);
        take_b(4'd9, 2'b00, 5);
        queues_empty("wrap");

        // Reset mid-burst abandons it without a B.
        exp_mem(32'h0000_2000, 64'hE0);
        send_aw(32'h0000_2000, 8'd3, 4'd5);
        send_w(64'hE0, 1'b0, 1'b0, 1'b0);
        bus.w_valid_i = 1'b1;
        bus.w_data_i  = 64'hE1;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_aw_ready", 64'(bus.aw_ready_o), 64'(1));
        check("midrst_b_valid", 64'(bus.b_valid_o), 64'(0));
        check("midrst_mem_req", 64'(bus.mem_req_o), 64'(0));
        check("midrst_w_ready", 64'(bus.w_ready_o), 64'(0));
        @(posedge clk);
        #1;
        bus.w_valid_i = 1'b0;
        exp_mem(32'h0000_2100, 64'hF0);
        exp_b(4'd6, 2'b00);
        send_aw(32'h0000_2100, 8'd0, 4'd6);
        send_w(64'hF0, 1'b1, 1'b0, 1'b0);
        take_b(4'd6, 2'b00, 0);
        queues_empty("reset");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
